// File: rtl/matrix_pkg.sv
// matrix_pkg: shared states, widths and element-extraction helper for the matrix batch sequencer
package matrix_pkg;
  localparam int ADDR_W = 4;
  localparam int ELEM_W = 5;
  localparam int DATA_W = 16;
  localparam int LAT_DEF = 3;
  localparam int Z_W = 4 * ELEM_W;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
  function automatic logic [DATA_W-1:0] elem_data(input logic [Z_W-1:0] z, input logic [1:0] e);
    return {{(DATA_W-ELEM_W){1'b0}}, z[ELEM_W*e +: ELEM_W]};
  endfunction
endpackage

// File: rtl/matrix_batch_seq.sv
// matrix_batch_seq: walks input memory 0..LAST_ADDR, waits LAT for z_in, writes its 4 elements out (clk/rst/start/abort/z_in in; in_addr/in_oe, out_addr/out_matrix_addr/out_we/out_data, busy/done/wr_count out)
module matrix_batch_seq import matrix_pkg::*; #(
  parameter int LAT = LAT_DEF,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [Z_W-1:0]    z_in,
  output logic [ADDR_W-1:0] in_addr,
  output logic              in_oe,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_matrix_addr,
  output logic              out_we,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [6:0]        wr_count
);
  state_t state;
  logic [7:0] cnt;
  logic [Z_W-1:0] hold;
  logic last;
  always_comb last = in_addr == LAST_ADDR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      in_addr <= '0;
      in_oe <= 1'b0;
      out_addr <= '0;
      out_matrix_addr <= '0;
      out_we <= 1'b0;
      out_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      wr_count <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
      in_oe <= 1'b0;
      out_we <= 1'b0;
      out_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state <= READ;
          in_addr <= '0;
          in_oe <= 1'b1;
          busy <= 1'b1;
          wr_count <= '0;
        end
        READ: begin
          state <= WAIT;
          cnt <= 8'(LAT - 1);
        end
        WAIT: if (cnt == 8'd0) begin
          state <= WRITE;
          hold <= z_in;
          in_oe <= 1'b0;
          out_we <= 1'b1;
          out_addr <= in_addr;
          out_matrix_addr <= 2'd0;
          out_data <= elem_data(z_in, 2'd0);
          wr_count <= wr_count + 7'd1;
        end else cnt <= cnt - 8'd1;
        WRITE: if (out_matrix_addr == 2'd3) begin
          out_we <= 1'b0;
          out_data <= '0;
          state <= last ? DONE : READ;
          done <= last;
          in_oe <= !last;
          in_addr <= last ? in_addr : in_addr + 4'd1;
        end else begin
          out_matrix_addr <= out_matrix_addr + 2'd1;
          out_data <= elem_data(hold, out_matrix_addr + 2'd1);
          wr_count <= wr_count + 7'd1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_batch_seq.sv
// tb_matrix_batch_seq: directed scoreboard bench for matrix_batch_seq with an external memory/multiplier model
module tb_matrix_batch_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [19:0] z_in;
  logic [3:0] in_addr, out_addr;
  logic in_oe, out_we, busy, done;
  logic [1:0] out_matrix_addr;
  logic [15:0] out_data;
  logic [6:0] wr_count;
  logic start3 = 1'b0;
  logic [3:0] in_addr3, out_addr3;
  logic in_oe3, out_we3, busy3, done3;
  logic [1:0] oma3;
  logic [15:0] out_data3;
  logic [6:0] wr_count3;
  int total = 0, bad = 0;
  int w3 = 0, d3 = 0, addr4 = 0, dsum3 = 0;
  logic [15:0] mem [16];
  logic [19:0] pipe [3];
  logic [21:0] q [$];
  logic [15:0] got_data [64];

  always #5 clk = ~clk;

  matrix_batch_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .z_in(z_in),
    .in_addr(in_addr), .in_oe(in_oe), .out_addr(out_addr), .out_matrix_addr(out_matrix_addr),
    .out_we(out_we), .out_data(out_data), .busy(busy), .done(done), .wr_count(wr_count)
  );

  matrix_batch_seq #(.LAST_ADDR(4'h3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .z_in(20'h12345),
    .in_addr(in_addr3), .in_oe(in_oe3), .out_addr(out_addr3), .out_matrix_addr(oma3),
    .out_we(out_we3), .out_data(out_data3), .busy(busy3), .done(done3), .wr_count(wr_count3)
  );

  function automatic logic [19:0] mm(input logic [15:0] w);
    logic [4:0] xa, xb, xc, xd, ya, yb, yc, yd;
    xa = 5'(w[1:0]);   xb = 5'(w[3:2]);   xc = 5'(w[5:4]);   xd = 5'(w[7:6]);
    ya = 5'(w[9:8]);   yb = 5'(w[11:10]); yc = 5'(w[13:12]); yd = 5'(w[15:14]);
    return {5'(xc*yb + xd*yd), 5'(xc*ya + xd*yc), 5'(xa*yb + xb*yd), 5'(xa*ya + xb*yc)};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= in_oe ? mm(mem[in_addr]) : 20'h5A5A5;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign z_in = pipe[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_we) begin
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL unexp_wr got addr=%0h elem=%0h exp no write", out_addr, out_matrix_addr);
      end
      if (q.size() > 0) begin
        chk("wr", {out_addr, out_matrix_addr, out_data}, q.pop_front());
        got_data[{out_addr, out_matrix_addr}] = out_data;
      end
    end
    if (out_we3) begin
      w3++;
      dsum3 += int'(out_data3) + int'(oma3);
    end
    if ((in_oe3 && in_addr3 > 4'd3) || (out_we3 && out_addr3 > 4'd3)) addr4++;
    if (done3) d3++;
  end

  task automatic batch(input int n, input int abort_k, input int rst_k, input bit poke,
                       input int done_exp, input int left_exp, input int wr_exp);
    int done_k;
    logic [19:0] zz;
    done_k = -1;
    for (int a = 0; a < 16; a++) begin
      zz = mm(mem[a]);
      for (int e = 0; e < 4; e++) q.push_back({4'(a), 2'(e), 11'b0, zz[5*e +: 5]});
    end
    @(negedge clk) start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k < 9) begin
        chk("oe_pat", in_oe, k < 4 || k == 8);
        chk("we_pat", out_we, k >= 4 && k < 8);
      end
      if (done && done_k < 0) done_k = k;
      if (k == done_exp + 1) chk("done_width", done, 0);
      if (poke && (k == 51 || k == 129)) begin
        start = 1'b0;
        chk("busy_poke", busy, k == 51);
      end
      if (poke && (k == 50 || k == 128)) start = 1'b1;
      if (k == abort_k + 1) begin
        abort = 1'b0;
        chk("abort_ctl", {out_we, in_oe, busy, done}, 0);
        chk("abort_cnt", wr_count, 22);
      end
      if (k == abort_k) abort = 1'b1;
      if (k == rst_k + 1) begin
        rst = 1'b0;
        chk("rst_ctl", {in_addr, in_oe, out_addr, out_matrix_addr, out_we, busy, done}, 0);
        chk("rst_data", {out_data, wr_count}, 0);
      end
      if (k == rst_k) rst = 1'b1;
    end
    chk("done_k", done_k, done_exp);
    chk("wr_count", wr_count, wr_exp);
    chk("q_left", q.size(), left_exp);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ctl", {in_addr, in_oe, out_addr, out_matrix_addr, out_we, busy, done}, 0);
    chk("reset_data", {out_data, wr_count}, 0);
    rst = 1'b0;
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk);
    chk("idle_abort_start", {busy, in_oe}, 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_stays", busy, 0);
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1E41;
    batch(135, 1000, 1000, 1'b0, 128, 0, 64);
    chk("ident_a", got_data[0], 16'h0002);
    chk("ident_b", got_data[1], 16'h0003);
    chk("ident_c", got_data[2], 16'h0001);
    chk("ident_d", got_data[3], 16'h0000);
    for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
    batch(135, 1000, 1000, 1'b1, 128, 0, 64);
    chk("sat_data", got_data[63], 16'h0012);
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    batch(60, 45, 1000, 1'b0, -1, 42, 22);
    batch(90, 1000, 74, 1'b0, -1, 28, 0);
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    repeat (40) @(negedge clk);
    chk("l3_writes", w3, 16);
    chk("l3_count", wr_count3, 16);
    chk("l3_done", d3, 1);
    chk("l3_addr4", addr4, 0);
    chk("l3_busy", busy3, 0);
    chk("l3_dsum", dsum3, 4 * (41 + 6));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
